// File: rtl/pg_pkg.sv
// Shared types and sizes for the burst gate: state encoding and bus widths.
package pg_pkg;

    localparam int CNT_W = 24;
    localparam int LEN_W = 16;
    localparam int NCH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pg_trig_sync.sv
// Brings the external trigger pin into the pulse clock domain and flags its
// rising edge as a one-cycle pulse.
module pg_trig_sync (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_trig,
    output logic o_rise
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Two-flop synchronizer plus a delayed copy used to spot the 0->1 transition.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= i_trig;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign o_rise = sync2 & ~sync2_d;

endmodule

// File: rtl/pg_burst_gate.sv
// Burst gate: opens the four channel pulse lines for a counted number of
// counter periods (or until stopped), always on period boundaries.
module pg_burst_gate
    import pg_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_res_n,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [NCH-1:0]   i_pulse,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_trig,
    input  logic             i_trig_en,
    input  logic [LEN_W-1:0] i_burst_len,
    output logic [NCH-1:0]   o_pulse,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_period_num
);

    logic [CNT_W-1:0] prev_cnt;
    logic             ps;
    logic             trig_rise;
    logic             start_req;
    pg_state_t        state;
    logic [LEN_W-1:0] len_q;
    logic             stop_pending;
    logic             run_end;
    logic             gate_next;
    logic             gate_eff;

    pg_trig_sync u_trig_sync (
        .i_clk   (i_clk),
        .i_res_n (i_res_n),
        .i_trig  (i_trig),
        .o_rise  (trig_rise)
    );

    assign start_req = i_start | (trig_rise & i_trig_en);

    // Remember last cycle's counter so a period start fires only on the step into zero.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            prev_cnt <= {CNT_W{1'b1}};
        end else begin
            prev_cnt <= i_cnt;
        end
    end

    assign ps = (i_cnt == '0) && (prev_cnt != '0);

    assign run_end = stop_pending || ((len_q != '0) && (o_period_num == len_q));

    // Gate state that will hold from the coming period start onward.
    always_comb begin
        gate_next = 1'b0;
        case (state)
            ARMED:   gate_next = !i_stop;
            RUN:     gate_next = !run_end;
            default: gate_next = 1'b0;
        endcase
    end

    assign gate_eff = ps ? gate_next : (state == RUN);

    // Burst sequencing with registered status outputs and the gated pulse register.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state        <= IDLE;
            o_pulse      <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_period_num <= '0;
            len_q        <= '0;
            stop_pending <= 1'b0;
        end else begin
            o_done  <= 1'b0;
            o_pulse <= i_pulse & {NCH{gate_eff}};
            case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start_req && !i_stop) begin
                        state  <= ARMED;
                        o_busy <= 1'b1;
                    end
                end
                ARMED: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (ps) begin
                        state        <= RUN;
                        len_q        <= i_burst_len;
                        o_period_num <= 16'd1;
                    end
                end
                RUN: begin
                    if (ps && run_end) begin
                        state        <= IDLE;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_period_num <= '0;
                        stop_pending <= 1'b0;
                    end else begin
                        if (ps) begin
                            o_period_num <= o_period_num + 16'd1;
                        end
                        if (i_stop) begin
                            stop_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
